// File: rtl/conv_acc_quant.sv
// ============================================================================
// Module   : conv_acc_quant
// Brief    : Per-pixel channel accumulator with bias add, rounding shift and
//            saturating quantisation. Optional macro RELU_EN enables ReLU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_acc_quant #(
  parameter int IN_W   = 21,
  parameter int ACC_W  = 32,
  parameter int NUM_CH = 16,
  parameter int BIAS_W = 16,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vld_i,
  input  logic signed [IN_W-1:0]   acc_i,
  input  logic                     clr_i,
  input  logic signed [BIAS_W-1:0] bias_i,
  input  logic [4:0]               shift_i,
  output logic signed [OUT_W-1:0]  out_o,
  output logic                     vld_o,
  output logic                     sat_o
);

  localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_CH - 1);
  localparam logic signed [ACC_W-1:0] C_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
`ifndef RELU_EN
  localparam logic signed [ACC_W-1:0] C_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         w_cnt_eff;
  logic                     w_first;
  logic                     w_last;
  logic signed [ACC_W-1:0]  w_acc_in;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_s1_vld;
  logic signed [BIAS_W-1:0] r_s1_bias;
  logic [4:0]               r_s1_shift;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  r_b;
  logic                     r_s2_vld;
  logic [4:0]               r_s2_shift;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_rsum;
  logic signed [ACC_W-1:0]  r_r;
  logic                     r_s3_vld;
  logic                     w_hi;
  logic signed [OUT_W-1:0]  w_out;
  logic                     w_sat;

  // A clear in the same cycle as a beat makes that beat the start of a new group.
  always_comb begin
    w_cnt_eff  = clr_i ? '0 : r_cnt;
    w_first    = (w_cnt_eff == '0);
    w_last     = (w_cnt_eff == C_LAST);
    w_acc_in   = {{(ACC_W-IN_W){acc_i[IN_W-1]}}, acc_i};
    w_bias_ext = {{(ACC_W-BIAS_W){r_s1_bias[BIAS_W-1]}}, r_s1_bias};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_bias  <= '0;
      r_s1_shift <= '0;
    end else begin
      r_s1_vld <= vld_i && w_last;
      if (vld_i) begin
        r_acc <= w_first ? w_acc_in : r_acc + w_acc_in;
        r_cnt <= w_last ? '0 : w_cnt_eff + CNT_W'(1);
        if (w_last) begin
          r_s1_bias  <= bias_i;
          r_s1_shift <= shift_i;
        end
      end else if (clr_i) begin
        r_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_b        <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_shift <= '0;
    end else begin
      r_b        <= r_acc + w_bias_ext;
      r_s2_vld   <= r_s1_vld;
      r_s2_shift <= r_s1_shift;
    end
  end

  // Adding half an LSB before the arithmetic shift rounds half toward +inf.
  always_comb begin
    w_rnd  = (r_s2_shift == 5'd0) ? '0 : (ACC_W'(1) << (r_s2_shift - 5'd1));
    w_rsum = r_b + w_rnd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_r      <= '0;
      r_s3_vld <= 1'b0;
    end else begin
      r_r      <= w_rsum >>> r_s2_shift;
      r_s3_vld <= r_s2_vld;
    end
  end

  always_comb begin
    w_hi = (r_r > C_MAX);
`ifdef RELU_EN
    // ReLU zeroing is not a saturation event; only the upper clamp flags sat.
    if (r_r[ACC_W-1]) begin
      w_out = '0;
      w_sat = 1'b0;
    end else if (w_hi) begin
      w_out = C_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else begin
      w_out = r_r[OUT_W-1:0];
      w_sat = 1'b0;
    end
`else
    if (w_hi) begin
      w_out = C_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (r_r < C_MIN) begin
      w_out = C_MIN[OUT_W-1:0];
      w_sat = 1'b1;
    end else begin
      w_out = r_r[OUT_W-1:0];
      w_sat = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_o <= '0;
      vld_o <= 1'b0;
      sat_o <= 1'b0;
    end else begin
      vld_o <= r_s3_vld;
      if (r_s3_vld) begin
        out_o <= w_out;
        sat_o <= w_sat;
      end
    end
  end

endmodule

`default_nettype wire
